// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder/subtractor, CHUNK bits per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int              c_N    = WIDTH / CHUNK;
   localparam int              c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_acc;
   logic              r_carry;
   logic [c_CW-1:0]   r_cnt;
   logic              r_armed;

   logic [CHUNK:0]    w_slice;
   logic              w_c_msb;
   logic [WIDTH-1:0]  w_acc_next;

   // Operands shift right each cycle, so the active slice is always the low CHUNK bits.
   assign w_slice    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, r_carry};
   assign w_c_msb    = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];
   assign w_acc_next = (r_acc >> CHUNK)
                     | (WIDTH'(w_slice[CHUNK-1:0]) << (WIDTH - CHUNK));

   // r_armed blocks a start on the edge that coincides with reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_armed <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         Cout    <= 1'b0;
         Ovf     <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         done    <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start && r_armed) begin
                  r_a     <= A;
                  r_b     <= Sub ? ~B : B;
                  r_carry <= Sub ? 1'b1 : Cin;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_slice[CHUNK];
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + c_ONE;
               if (r_cnt == c_LAST) begin
                  S       <= w_acc_next;
                  Cout    <= w_slice[CHUNK];
                  Ovf     <= w_c_msb ^ w_slice[CHUNK];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder over several WIDTH/CHUNK builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int c_NDUT = 7;

   function automatic int width_of(input int k);
      return (k < 4) ? 8 : 16;
   endfunction

   function automatic int chunk_of(input int k);
      case (k)
         0: return 1;
         1: return 2;
         2: return 4;
         3: return 8;
         4: return 1;
         5: return 2;
         default: return 16;
      endcase
   endfunction

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [15:0]               a_in = '0;
   logic [15:0]               b_in = '0;
   logic                      cin_in = 1'b0;
   logic                      sub_in = 1'b0;
   logic [c_NDUT-1:0]         start_v = '0;
   logic [c_NDUT-1:0]         busy_v;
   logic [c_NDUT-1:0]         done_v;
   logic [c_NDUT-1:0]         cout_v;
   logic [c_NDUT-1:0]         ovf_v;
   logic [c_NDUT-1:0][15:0]   s_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < c_NDUT; g++) begin : g_dut
         localparam int W = width_of(g);
         localparam int C = chunk_of(g);
         serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .A     (a_in[W-1:0]),
            .B     (b_in[W-1:0]),
            .Cin   (cin_in),
            .Sub   (sub_in),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .S     (s_v[g][W-1:0]),
            .Cout  (cout_v[g]),
            .Ovf   (ovf_v[g])
         );
         if (W < 16) begin : g_pad
            assign s_v[g][15:W] = '0;
         end
      end
   endgenerate

   // Reference: plain integer arithmetic and sign-rule overflow.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub,
                                 output logic [15:0] s, output logic cout, output logic ovf);
      longint unsigned mask, ua, ub, full;
      bit sa, sb, ss;
      mask = (64'd1 << w) - 1;
      ua   = a & mask;
      ub   = (sub ? ~{48'd0, b} : {48'd0, b}) & mask;
      full = ua + ub + (sub ? 1 : cin);
      s    = 16'(full & mask);
      cout = full[w];
      sa   = ua[w-1];
      sb   = ub[w-1];
      ss   = full[w-1];
      ovf  = (sa == sb) && (ss != sa);
   endfunction

   task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
      int          n, lat;
      bit          got;
      logic [15:0] es, prev_s;
      logic        ec, eo;
      n = width_of(k) / chunk_of(k);
      model(width_of(k), a, b, cin, sub, es, ec, eo);
      @(negedge clk);
      a_in = a; b_in = b; cin_in = cin; sub_in = sub;
      start_v[k] = 1'b1;
      prev_s = s_v[k];
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      a_in = 16'($urandom); b_in = 16'($urandom);
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      checks++;
      if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
         errors++;
         $display("FAIL op_start dut%0d: busy=%b done=%b required busy=1 done=0", k, busy_v[k], done_v[k]);
      end
      lat = 0;
      got = 0;
      while (!got && lat < n + 3) begin
         @(posedge clk); #1;
         lat++;
         if (done_v[k] === 1'b1) begin
            got = 1;
         end else begin
            checks++;
            if (busy_v[k] !== 1'b1 || s_v[k] !== prev_s) begin
               errors++;
               $display("FAIL op_hold dut%0d cyc%0d: busy=%b S=%h required busy=1 S=%h",
                        k, lat, busy_v[k], s_v[k], prev_s);
            end
         end
      end
      checks++;
      if (!got || lat != n || busy_v[k] !== 1'b0) begin
         errors++;
         $display("FAIL op_latency dut%0d: done_seen=%0d latency=%0d busy=%b required latency=%0d busy=0",
                  k, got, lat, busy_v[k], n);
      end
      checks++;
      if (s_v[k] !== es || cout_v[k] !== ec || ovf_v[k] !== eo) begin
         errors++;
         $display("FAIL op_result dut%0d a=%h b=%h cin=%b sub=%b: S=%h Cout=%b Ovf=%b required S=%h Cout=%b Ovf=%b",
                  k, a, b, cin, sub, s_v[k], cout_v[k], ovf_v[k], es, ec, eo);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < c_NDUT; k++) begin
         checks++;
         if ({busy_v[k], done_v[k], cout_v[k], ovf_v[k]} !== 4'b0 || s_v[k] !== 16'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0",
                     k, busy_v[k], done_v[k], s_v[k], cout_v[k], ovf_v[k]);
         end
      end
      @(negedge clk);
      start_v = '1;
      @(posedge clk);
      rst_n = 1'b1;
      #1;
      start_v = '0;
      checks++;
      if (busy_v !== '0) begin
         errors++;
         $display("FAIL start_at_release: busy=%b required 0", busy_v);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_v !== '0 || done_v !== '0) begin
         errors++;
         $display("FAIL start_at_release_next: busy=%b done=%b required 0", busy_v, done_v);
      end
   endtask

   task automatic test_directed();
      do_op(0, 16'h005A, 16'h003C, 1'b0, 1'b0);
      checks++;
      if (s_v[0] !== 16'h0096 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL directed_5a_3c: S=%h Cout=%b Ovf=%b required S=96 Cout=0 Ovf=1",
                  s_v[0], cout_v[0], ovf_v[0]);
      end
      do_op(0, 16'h00FF, 16'h0001, 1'b1, 1'b0);
      checks++;
      if (s_v[0] !== 16'h0001 || cout_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL directed_ff_01: S=%h Cout=%b Ovf=%b required S=01 Cout=1 Ovf=0",
                  s_v[0], cout_v[0], ovf_v[0]);
      end
      do_op(2, 16'h0010, 16'h0020, 1'b1, 1'b1);
      checks++;
      if (s_v[2] !== 16'h00F0 || cout_v[2] !== 1'b0 || ovf_v[2] !== 1'b0) begin
         errors++;
         $display("FAIL directed_sub_chunk4: S=%h Cout=%b Ovf=%b required S=f0 Cout=0 Ovf=0",
                  s_v[2], cout_v[2], ovf_v[2]);
      end
      do_op(3, 16'h0080, 16'h0080, 1'b0, 1'b0);
      do_op(6, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int          dones;
      logic [15:0] es1, es3;
      logic        ec1, eo1, ec3, eo3;
      model(8, 16'h0033, 16'h0044, 1'b1, 1'b0, es1, ec1, eo1);
      model(8, 16'h00C1, 16'h0017, 1'b0, 1'b1, es3, ec3, eo3);
      @(negedge clk);
      a_in = 16'h0033; b_in = 16'h0044; cin_in = 1'b1; sub_in = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      dones = 0;
      for (int e = 1; e <= 8; e++) begin
         if (e == 3) begin
            @(negedge clk);
            a_in = 16'h00EE; b_in = 16'h0011; cin_in = 1'b0; sub_in = 1'b1;
            start_v[0] = 1'b1;
         end
         @(posedge clk); #1;
         start_v[0] = 1'b0;
         if (done_v[0] === 1'b1) dones++;
      end
      checks++;
      if (dones != 1 || done_v[0] !== 1'b1 || s_v[0] !== es1 || cout_v[0] !== ec1 || ovf_v[0] !== eo1) begin
         errors++;
         $display("FAIL ignore_start: dones=%0d done=%b S=%h Cout=%b Ovf=%b required dones=1 done=1 S=%h Cout=%b Ovf=%b",
                  dones, done_v[0], s_v[0], cout_v[0], ovf_v[0], es1, ec1, eo1);
      end
      @(negedge clk);
      a_in = 16'h00C1; b_in = 16'h0017; cin_in = 1'b0; sub_in = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      checks++;
      if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start: busy=%b done=%b required busy=1 done=0", busy_v[0], done_v[0]);
      end
      dones = 0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1) dones++;
      end
      checks++;
      if (dones != 1 || done_v[0] !== 1'b1 || s_v[0] !== es3 || cout_v[0] !== ec3 || ovf_v[0] !== eo3) begin
         errors++;
         $display("FAIL b2b_result: dones=%0d done=%b S=%h Cout=%b Ovf=%b required dones=1 done=1 S=%h Cout=%b Ovf=%b",
                  dones, done_v[0], s_v[0], cout_v[0], ovf_v[0], es3, ec3, eo3);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b done=%b required 0", busy_v[0], done_v[0]);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a_in = 16'h00A5; b_in = 16'h005A; cin_in = 1'b0; sub_in = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || s_v[0] !== 16'h0 ||
          cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0",
                  busy_v[0], done_v[0], s_v[0], cout_v[0], ovf_v[0]);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk); #1;
         checks++;
         if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done cyc%0d: busy=%b done=%b required 0", e, busy_v[0], done_v[0]);
         end
      end
      do_op(0, 16'h00A5, 16'h005A, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < c_NDUT; k++) begin
         for (int i = 0; i < 10; i++) begin
            do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), i[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
